// File: rtl/cr_su_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cr_su_arb_pkg
// Description : Shared types and the round-robin pick helper for cr_su_arb.
// Revision    : 1.0 - initial release
// ============================================================================

package cr_su_arb_pkg;

    localparam int c_MAX_REQ   = 8;
    localparam int c_MAX_IDX_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } su_arb_state_e;

    // Returns {found, index} of the first set bit of cand at or after ptr,
    // wrapping modulo n. Only the low n bits of cand are considered.
    function automatic logic [c_MAX_IDX_W:0] rr_pick(
        input logic [c_MAX_REQ-1:0]   cand,
        input logic [c_MAX_IDX_W-1:0] ptr,
        input int                     n
    );
        logic                   found;
        logic [c_MAX_IDX_W-1:0] idx;
        int                     j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < c_MAX_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= n) begin
                j = j - n;
            end
            if ((k < n) && !found && cand[j[c_MAX_IDX_W-1:0]]) begin
                found = 1'b1;
                idx   = j[c_MAX_IDX_W-1:0];
            end
        end
        return {found, idx};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cr_su_arb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : cr_su_arb_fifo
// Description : Two-entry register FIFO; the head entry is always r_head so
//               the output is taken straight from a register.
// Revision    : 1.0 - initial release
// ============================================================================

module cr_su_arb_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] r_head;
    logic [W-1:0] r_tail;
    logic [1:0]   r_count;
    logic         w_pop;
    logic         w_push;

    assign w_pop  = pop & (r_count != 2'd0);
    assign w_push = push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head <= din;
                    end else begin
                        r_tail <= din;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new beat lands behind whatever remains.
                    if (r_count == 2'd1) begin
                        r_head <= din;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout  = r_head;
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/cr_su_arb.sv
`default_nettype none
// ============================================================================
// Module      : cr_su_arb
// Description : Round-robin arbiter sharing the cr_su update input; a grant is
//               held for a whole multi-beat update and beats leave via a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================

module cr_su_arb
    import cr_su_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ-1:0]         req_last,
    input  logic [N_REQ*DW-1:0]      req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_mask,
    output logic                     su_valid,
    output logic                     su_last,
    output logic [DW-1:0]            su_data,
    output logic [$clog2(N_REQ)-1:0] su_src,
    input  logic                     su_ready,
    output logic                     arb_busy
);

    localparam int            SW         = $clog2(N_REQ);
    localparam int            BW         = 1 + SW + DW;
    localparam logic [SW-1:0] c_LAST_IDX = SW'(N_REQ - 1);

    typedef struct packed {
        logic          last;
        logic [SW-1:0] src;
        logic [DW-1:0] data;
    } su_arb_beat_t;

    su_arb_state_e          r_state;
    logic [SW-1:0]          r_gnt_idx;
    logic [SW-1:0]          r_rr_ptr;

    logic [1:0]             w_count;
    logic                   w_space;
    logic                   w_push;
    logic                   w_pop;
    logic [c_MAX_REQ-1:0]   w_cand;
    logic [c_MAX_IDX_W-1:0] w_ptr_ext;
    logic [c_MAX_IDX_W:0]   w_pick;
    logic [SW-1:0]          w_win;
    logic [N_REQ-1:0]       w_ready;
    su_arb_beat_t           w_push_beat;
    su_arb_beat_t           w_head;

    always_comb begin
        w_cand                = '0;
        w_cand[N_REQ-1:0]     = req_valid & ~req_mask;
        w_ptr_ext             = '0;
        w_ptr_ext[SW-1:0]     = r_rr_ptr;
    end

    assign w_pick  = rr_pick(w_cand, w_ptr_ext, N_REQ);
    assign w_space = (w_count != 2'd2);

    // In LOCK the owner is fixed; in IDLE the round-robin winner is used.
    always_comb begin
        w_win = r_gnt_idx;
        if (r_state == IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_pick[c_MAX_IDX_W-1:0] == c_MAX_IDX_W'(i)) begin
                    w_win = SW'(i);
                end
            end
        end
    end

    always_comb begin
        w_ready = '0;
        if (w_space) begin
            if (r_state == IDLE) begin
                if (w_pick[c_MAX_IDX_W]) begin
                    w_ready[w_win] = 1'b1;
                end
            end else if (req_valid[r_gnt_idx]) begin
                w_ready[r_gnt_idx] = 1'b1;
            end
        end
    end

    // Held low during reset even though candidates may already be present.
    assign req_ready = w_ready & {N_REQ{rst_n}};
    assign w_push    = |req_ready;
    assign w_pop     = su_valid & su_ready;

    always_comb begin
        w_push_beat.last = 1'b0;
        w_push_beat.src  = w_win;
        w_push_beat.data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_win == SW'(i)) begin
                w_push_beat.last = req_last[i];
                w_push_beat.data = req_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_gnt_idx <= '0;
            r_rr_ptr  <= '0;
        end else if (w_push) begin
            if (w_push_beat.last) begin
                r_state  <= IDLE;
                r_rr_ptr <= (w_win == c_LAST_IDX) ? '0 : w_win + SW'(1);
            end else begin
                r_state   <= LOCK;
                r_gnt_idx <= w_win;
            end
        end
    end

    cr_su_arb_fifo #(
        .W (BW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   (w_push_beat),
        .pop   (w_pop),
        .dout  (w_head),
        .count (w_count)
    );

    assign su_valid = (w_count != 2'd0);
    assign su_last  = w_head.last;
    assign su_src   = w_head.src;
    assign su_data  = w_head.data;
    assign arb_busy = su_valid | (r_state == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_cr_su_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_cr_su_arb
// Description : Self-checking bench for cr_su_arb with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_cr_su_arb;

    localparam int N  = 4;
    localparam int DW = 64;

    typedef struct packed {
        logic          last;
        logic [1:0]    src;
        logic [DW-1:0] data;
    } beat_t;

    typedef struct packed {
        logic          valid;
        logic          busy;
        logic [N-1:0]  rdy;
        beat_t         b;
    } cyc_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_last = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_mask = '0;
    logic            su_valid;
    logic            su_last;
    logic [DW-1:0]   su_data;
    logic [1:0]      su_src;
    logic            su_ready = 1'b1;
    logic            arb_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW:0]  dq[N][$];
    logic [N-1:0] en    = '1;
    logic [N-1:0] mask  = '0;
    logic         sready = 1'b1;
    int unsigned  seq   = 0;

    beat_t m_fifo[$];
    int    m_owner = -1;
    int    m_ptr   = 0;

    cyc_t  obs_cyc[$];
    cyc_t  exp_cyc[$];
    beat_t obs_beats[$];

    cr_su_arb #(.N_REQ(N), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_last  (req_last),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_mask  (req_mask),
        .su_valid  (su_valid),
        .su_last   (su_last),
        .su_data   (su_data),
        .su_src    (su_src),
        .su_ready  (su_ready),
        .arb_busy  (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic add_update(input int r, input int len);
        for (int b = 0; b < len; b++) begin
            dq[r].push_back({(b == len - 1), 8'(r), 8'(b), 16'(0), 32'(seq)});
            seq++;
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (dq[i].size() > 0 && en[i]) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = dq[i][0][DW];
                req_data[i*DW +: DW]  = dq[i][0][DW-1:0];
            end else begin
                req_valid[i]          = 1'b0;
                req_last[i]           = 1'b0;
                req_data[i*DW +: DW]  = '0;
            end
        end
        req_mask = mask;
        su_ready = sready;
    endtask

    // Reference: which requester the arbiter must accept this cycle.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        r = '0;
        if (rst_n !== 1'b1 || m_fifo.size() >= 2) return r;
        if (m_owner >= 0) begin
            r[m_owner] = req_valid[m_owner];
            return r;
        end
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (req_valid[j] && !req_mask[j]) begin
                r[j] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic [N-1:0] rdy);
        if (m_fifo.size() > 0 && sready) void'(m_fifo.pop_front());
        for (int i = 0; i < N; i++) begin
            if (rdy[i]) begin
                beat_t bt;
                bt.last = dq[i][0][DW];
                bt.src  = 2'(i);
                bt.data = dq[i][0][DW-1:0];
                m_fifo.push_back(bt);
                void'(dq[i].pop_front());
                if (bt.last) begin
                    m_owner = -1;
                    m_ptr   = (i + 1) % N;
                end else begin
                    m_owner = i;
                end
            end
        end
    endtask

    function automatic bit model_idle();
        for (int i = 0; i < N; i++) if (dq[i].size() > 0) return 1'b0;
        return (m_fifo.size() == 0) && (m_owner < 0);
    endfunction

    task automatic tick();
        cyc_t o, e;
        drive_inputs();
        #1;
        e.rdy   = model_ready();
        e.valid = (m_fifo.size() > 0);
        e.busy  = e.valid || (m_owner >= 0);
        e.b     = '0;
        if (e.valid) e.b = m_fifo[0];
        o.rdy   = req_ready;
        o.valid = su_valid;
        o.busy  = arb_busy;
        o.b     = '0;
        if (su_valid) begin
            o.b.last = su_last;
            o.b.src  = su_src;
            o.b.data = su_data;
        end
        obs_cyc.push_back(o);
        exp_cyc.push_back(e);
        if (su_valid && su_ready) obs_beats.push_back(o.b);
        @(posedge clk);
        model_step(e.rdy);
        @(negedge clk);
    endtask

    task automatic drain(input int max);
        en     = '1;
        mask   = '0;
        sready = 1'b1;
        for (int c = 0; c < max; c++) begin
            if (model_idle()) break;
            tick();
        end
        tick();
    endtask

    task automatic clear_rec();
        obs_cyc.delete();
        exp_cyc.delete();
        obs_beats.delete();
    endtask

    task automatic test_reset();
        req_valid = '1;
        req_mask  = '0;
        su_ready  = 1'b1;
        #3;
        n_tests += 6;
        if (req_ready !== '0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0000", req_ready); end
        if (su_valid !== 1'b0) begin n_fail++; $display("FAIL rst_su_valid: got %b expected 0", su_valid); end
        if (su_last !== 1'b0) begin n_fail++; $display("FAIL rst_su_last: got %b expected 0", su_last); end
        if (su_data !== '0) begin n_fail++; $display("FAIL rst_su_data: got %h expected 0", su_data); end
        if (su_src !== 2'd0) begin n_fail++; $display("FAIL rst_su_src: got %0d expected 0", su_src); end
        if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", arb_busy); end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        clear_rec();
        add_update(0, 3);
        drain(20);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL single cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests += 4;
        if (obs_cyc[0].rdy !== 4'b0001 || obs_cyc[0].valid !== 1'b0) begin
            n_fail++; $display("FAIL single_accept: got rdy %b valid %b expected 0001 0", obs_cyc[0].rdy, obs_cyc[0].valid);
        end
        if (obs_cyc[1].valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: got %b expected 1", obs_cyc[1].valid); end
        if (obs_cyc[3].b.last !== 1'b1) begin n_fail++; $display("FAIL single_last: got %b expected 1", obs_cyc[3].b.last); end
        if (obs_beats.size() != 3) begin n_fail++; $display("FAIL single_count: got %0d expected 3", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size() && k < 3; k++) begin
            n_tests++;
            if ({obs_beats[k].last, obs_beats[k].src} !== {(k == 2), 2'd0}) begin
                n_fail++; $display("FAIL single_beat%0d: got last %b src %0d", k, obs_beats[k].last, obs_beats[k].src);
            end
        end
        // After req0 finishes, req1 has priority over req0.
        clear_rec();
        add_update(1, 1);
        add_update(0, 1);
        tick();
        n_tests++;
        if (obs_cyc[0].rdy !== 4'b0010) begin n_fail++; $display("FAIL single_ptr: got %b expected 0010", obs_cyc[0].rdy); end
        drain(20);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL ptr cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
    endtask

    task automatic test_fairness();
        int f;
        clear_rec();
        for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) add_update(i, 1);
        drain(40);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL fair cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests++;
        if (obs_beats.size() != 12) begin n_fail++; $display("FAIL fair_count: got %0d expected 12", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size() && k < 12; k++) begin
            n_tests++;
            if (obs_beats[k].src !== 2'((1 + k) % 4)) begin
                n_fail++; $display("FAIL fair_src%0d: got %0d expected %0d", k, obs_beats[k].src, (1 + k) % 4);
            end
        end
        f = 0;
        while (f < obs_cyc.size() && obs_cyc[f].valid !== 1'b1) f++;
        for (int k = 0; k < 12; k++) begin
            n_tests++;
            if (f + k >= obs_cyc.size() || obs_cyc[f+k].valid !== 1'b1) begin
                n_fail++; $display("FAIL fair_gap%0d: su_valid not continuous", k);
            end
        end
    endtask

    task automatic test_no_interleave();
        int exp_src[6];
        exp_src = '{1, 1, 1, 1, 2, 0};
        clear_rec();
        add_update(1, 4);
        add_update(0, 1);
        add_update(2, 1);
        drain(30);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL nointlv cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests++;
        if (obs_beats.size() != 6) begin n_fail++; $display("FAIL nointlv_count: got %0d expected 6", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size() && k < 6; k++) begin
            n_tests++;
            if (obs_beats[k].src !== 2'(exp_src[k])) begin
                n_fail++; $display("FAIL nointlv_src%0d: got %0d expected %0d", k, obs_beats[k].src, exp_src[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] exp_data[6];
        int            n_acc;
        clear_rec();
        add_update(3, 6);
        for (int k = 0; k < 6; k++) exp_data[k] = dq[3][k][DW-1:0];
        sready = 1'b0;
        for (int c = 0; c < 10; c++) tick();
        n_acc = 0;
        for (int c = 0; c < 10; c++) if (obs_cyc[c].rdy !== '0) n_acc++;
        n_tests += 2;
        if (n_acc != 2) begin n_fail++; $display("FAIL bp_accepts: got %0d expected 2", n_acc); end
        if (obs_cyc[9].b.data !== exp_data[0] || obs_cyc[9].valid !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold: got %h expected %h", obs_cyc[9].b.data, exp_data[0]);
        end
        for (int c = 2; c < 10; c++) begin
            n_tests++;
            if (obs_cyc[c].b !== obs_cyc[1].b) begin n_fail++; $display("FAIL bp_stable%0d: got %h expected %h", c, obs_cyc[c].b, obs_cyc[1].b); end
        end
        drain(30);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL bp cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests++;
        if (obs_beats.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", obs_beats.size()); end
        for (int k = 0; k < obs_beats.size() && k < 6; k++) begin
            n_tests++;
            if ({obs_beats[k].last, obs_beats[k].src, obs_beats[k].data} !== {(k == 5), 2'd3, exp_data[k]}) begin
                n_fail++; $display("FAIL bp_beat%0d: got %h expected %h", k, obs_beats[k].data, exp_data[k]);
            end
        end
    endtask

    task automatic test_masking();
        int exp1[8];
        int exp2[3];
        exp1 = '{1, 1, 1, 1, 2, 0, 2, 0};
        exp2 = '{1, 2, 0};
        clear_rec();
        en = 4'b0010;
        add_update(1, 4);
        tick();
        mask = 4'b0010;
        en   = '1;
        add_update(0, 1); add_update(0, 1);
        add_update(2, 1); add_update(2, 1);
        add_update(1, 1);
        for (int c = 0; c < 12; c++) tick();
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL mask cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests += 2;
        if (obs_beats.size() != 8) begin n_fail++; $display("FAIL mask_count: got %0d expected 8", obs_beats.size()); end
        if (obs_cyc[obs_cyc.size()-1].rdy !== '0 || obs_cyc[obs_cyc.size()-1].busy !== 1'b0) begin
            n_fail++; $display("FAIL mask_skip: got rdy %b busy %b expected 0000 0", obs_cyc[obs_cyc.size()-1].rdy, obs_cyc[obs_cyc.size()-1].busy);
        end
        for (int k = 0; k < obs_beats.size() && k < 8; k++) begin
            n_tests++;
            if (obs_beats[k].src !== 2'(exp1[k])) begin n_fail++; $display("FAIL mask_src%0d: got %0d expected %0d", k, obs_beats[k].src, exp1[k]); end
        end
        clear_rec();
        mask = '0;
        add_update(2, 1);
        add_update(0, 1);
        drain(20);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL unmask cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (k >= obs_beats.size() || obs_beats[k].src !== 2'(exp2[k])) begin
                n_fail++; $display("FAIL unmask_src%0d: expected %0d", k, exp2[k]);
            end
        end
    endtask

    task automatic test_reset_mid_update();
        logic [DW-1:0] first2;
        clear_rec();
        add_update(2, 1);
        tick();
        add_update(3, 5);
        tick();
        tick();
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL prerst cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests += 6;
        if (req_ready !== '0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0000", req_ready); end
        if (su_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", su_valid); end
        if (su_last !== 1'b0) begin n_fail++; $display("FAIL midrst_last: got %b expected 0", su_last); end
        if (su_data !== '0) begin n_fail++; $display("FAIL midrst_data: got %h expected 0", su_data); end
        if (su_src !== 2'd0) begin n_fail++; $display("FAIL midrst_src: got %0d expected 0", su_src); end
        if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", arb_busy); end
        m_fifo.delete();
        m_owner = -1;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) dq[i].delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_rec();
        add_update(3, 1);
        add_update(2, 3);
        first2 = dq[2][0][DW-1:0];
        drain(30);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL postrst cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests++;
        if (obs_beats.size() == 0 || obs_beats[0].src !== 2'd2 || obs_beats[0].data !== first2) begin
            n_fail++; $display("FAIL postrst_first: expected src 2 data %h", first2);
        end
    endtask

    task automatic test_random();
        int added;
        clear_rec();
        added = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (dq[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int len;
                    len = $urandom_range(1, 4);
                    add_update(i, len);
                    added += len;
                end
            end
            en     = 4'($urandom);
            mask   = 4'($urandom);
            sready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(300);
        foreach (exp_cyc[i]) begin
            n_tests++;
            if (obs_cyc[i] !== exp_cyc[i]) begin n_fail++; $display("FAIL random cyc%0d: got %h expected %h", i, obs_cyc[i], exp_cyc[i]); end
        end
        n_tests++;
        if (obs_beats.size() != added) begin n_fail++; $display("FAIL random_count: got %0d expected %0d", obs_beats.size(), added); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_no_interleave();
        test_backpressure();
        test_masking();
        test_reset_mid_update();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

`default_nettype wire

// File: doc/cr_su_arb.md
# cr_su_arb

Round-robin arbiter that shares the single scheduler-update input of `cr_su` between `N_REQ` upstream engines. It grants one requester at a time and holds the grant for the whole multi-beat update, up to and including the beat marked `last`, so updates are never interleaved. Accepted beats pass through a two-entry output FIFO that drives `su_in`/`su_ready` of `cr_su`. This keeps full throughput and isolates upstream ready timing from `su_ready`.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DW`, 64: update payload width per beat.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous assert, active-low.
- `req_valid` input N_REQ: per-requester beat valid.
- `req_last` input N_REQ: per-requester last beat of update.
- `req_data` input N_REQ*DW: per-requester payload; slice i is `[i*DW +: DW]`.
- `req_ready` output N_REQ: per-requester beat accepted when ready & valid.
- `req_mask` input N_REQ: 1 = requester excluded from new grants.
- `su_valid` output 1: beat valid toward `cr_su`.
- `su_last` output 1: last beat of update.
- `su_data` output DW: payload toward `cr_su`.
- `su_src` output log2(N_REQ): index of the requester that sourced the beat.
- `su_ready` input 1: `cr_su` accepts beat.
- `arb_busy` output 1: FIFO non-empty or grant locked.

## Operation
- **State machine:** `IDLE`, `LOCK`.
  - In `IDLE`: candidates = `req_valid & ~req_mask`. Pick the first candidate at or after `rr_ptr`, wrapping modulo N_REQ.
  - A grant is issued only if the FIFO has space (count<2).
  - Winner's beat is accepted the same cycle: `req_ready[w]=1`.
  - If that beat has `last`=0, go to `LOCK` with `gnt_idx=w`. If `last`=1, stay in `IDLE`.
  - On every accepted `last` beat, `rr_ptr ← (w+1) mod N_REQ`.
- **In `LOCK`:** only `gnt_idx` may be accepted. Acceptance requires FIFO space and `req_valid[gnt_idx]`. Return to `IDLE` on its accepted `last` beat.
  - `req_mask` is ignored in `LOCK`. Masking never truncates an update.
- **`req_ready`:** at most one bit high. It is combinational from state, FIFO count, candidates and `rr_ptr`. It does not depend on `su_ready`.
- **FIFO:** 2 entries of {last, src, data}. Push on accepted request beat; pop on `su_valid & su_ready`.
  - Simultaneous push and pop leaves count unchanged.
  - Full (count=2) blocks all grants.
  - `su_valid` = count≠0, driven from the head entry register.
- **Masking:**
  - No candidate: no grant, `rr_ptr` unchanged.
  - A requester with `req_valid` high but masked in `IDLE` is skipped. Its valid may stay high indefinitely.
- **`arb_busy`** = (count≠0) | (state==`LOCK`).

## Timing
- **Reset values:**
  - State `IDLE`, `rr_ptr`=0, FIFO count=0.
  - `su_valid`=0, `su_last`=0, `su_data`=0, `su_src`=0.
  - `req_ready`=0 while in reset.
  - `arb_busy`=0.
- **Latency:** beat accepted at cycle t is visible on `su_valid` at t+1 if FIFO was empty.
- **Throughput:** with `su_ready` held 1, one beat per cycle sustained, including back-to-back updates from different requesters.
- **`su_ready` low:** FIFO fills after 2 accepted beats, then `req_ready` all 0 from the next cycle until a pop.
- **Output hold:** `su_valid`/`su_data`/`su_last`/`su_src` hold stable while `su_valid & ~su_ready` (AXI-stream rule).
- **Reset mid-update:** lock, FIFO and pointer are cleared immediately. Requesters restart whole updates after reset; no partial-update recovery.

## Structure
- **`cr_suPKG`:** add `su_arb_state_e` {`IDLE`,`LOCK`} and a `su_arb_beat_t` struct {last, src, data}.
- **`cr_su_arb_fifo`:** one sub-module, a 2-entry register FIFO with push/pop/count. Arbitration and FSM stay in the top.

## Test plan
- **Single requester:** req0 sends 3-beat update, `su_ready`=1 -> `su_valid` cycles t+1..t+3, `su_last` on third, `su_src`=0, `rr_ptr`=1 afterwards.
- **Fairness:** all 4 requesters continuously valid with 1-beat updates -> grant order 0,1,2,3,0,1… with no gaps.
- **No interleave:** req1 4-beat update with req0 and req2 valid throughout -> all 4 beats `su_src`=1 consecutively, then req2 granted, then req0.
- **Backpressure:** `su_ready`=0 for 10 cycles during req3 update -> exactly 2 beats accepted, `req_ready`=0 thereafter, outputs stable. Release -> remaining beats in order, none lost or duplicated.
- **Masking:** mask req1 while it is in `LOCK` -> update completes. Mask persists -> req1 never granted again while req0/req2 proceed. Unmask -> req1 granted at its round-robin turn.
- **Reset mid-update:** assert `rst_n`=0 after beat 2 of 5 -> all outputs at reset values asynchronously. After release, new update from req2 arrives first-beat intact with `rr_ptr`=0 priority.
